// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt controller: register map and FSM state type.
package intr_pkg;

    // Word offsets from the block base address
    localparam logic [31:0] PEND_OFS = 32'h0000_0000;
    localparam logic [31:0] EN_OFS   = 32'h0000_0004;
    localparam logic [31:0] ID_OFS   = 32'h0000_0008;
    localparam logic [31:0] ACK_OFS  = 32'h0000_000C;
    localparam logic [31:0] OVF_OFS  = 32'h0000_0010;

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        HOLDOFF
    } intr_state_t;

endpackage

// File: rtl/intr_ctrl_if.sv
// OTTER I/O bus as seen by a memory-mapped peripheral.
interface intr_ctrl_if;

    logic [31:0] iobus_addr;
    logic [31:0] iobus_out;
    logic        iobus_wr;
    logic [31:0] iobus_rd;

    modport master (
        output iobus_addr,
        output iobus_out,
        output iobus_wr,
        input  iobus_rd
    );

    modport slave (
        input  iobus_addr,
        input  iobus_out,
        input  iobus_wr,
        output iobus_rd
    );

endinterface

// File: rtl/prio_enc.sv
// Fixed-priority encoder: the lowest set request bit wins.
module prio_enc #(
    parameter int unsigned N   = 8,
    parameter int unsigned IdW = 3
) (
    input  logic [N-1:0]   req_i,
    output logic           valid_o,
    output logic [IdW-1:0] idx_o
);

    // Scan from the top down so the lowest set index is the last one written
    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IdW'(i);
            end
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// Memory-mapped interrupt controller: edge capture, enable masking, fixed priority
// and an assert / acknowledge / holdoff sequencer driving the MCU INTR line.
module intr_ctrl #(
    parameter int unsigned N_SRC       = 5,
    parameter int unsigned HOLDOFF_CYC = 4,
    parameter logic [31:0] BASE_ADDR   = 32'h1100_D000,
    localparam int unsigned IdW        = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_SRC-1:0] src,
    intr_ctrl_if.slave       bus,
    output logic             intr,
    output logic [IdW-1:0]   intr_id
);

    import intr_pkg::*;

    localparam int unsigned CntW = $clog2(HOLDOFF_CYC + 1);

    logic [N_SRC-1:0] src_q, pend_q, en_q, ovf_q;
    logic [N_SRC-1:0] evt, act, pend_clr, ovf_clr, ovf_set;
    logic             hit_pend, hit_en, hit_id, hit_ack, hit_ovf;
    logic             wr_pend, wr_en, wr_ack, wr_ovf;
    logic             act_valid;
    logic [IdW-1:0]   act_id;
    logic [31:0]      rd_data;
    intr_state_t      state_q;
    logic [CntW-1:0]  cnt_q;

    assign hit_pend = (bus.iobus_addr == BASE_ADDR + PEND_OFS);
    assign hit_en   = (bus.iobus_addr == BASE_ADDR + EN_OFS);
    assign hit_id   = (bus.iobus_addr == BASE_ADDR + ID_OFS);
    assign hit_ack  = (bus.iobus_addr == BASE_ADDR + ACK_OFS);
    assign hit_ovf  = (bus.iobus_addr == BASE_ADDR + OVF_OFS);

    assign wr_pend = bus.iobus_wr & hit_pend;
    assign wr_en   = bus.iobus_wr & hit_en;
    assign wr_ack  = bus.iobus_wr & hit_ack;
    assign wr_ovf  = bus.iobus_wr & hit_ovf;

    assign evt = src & ~src_q;
    assign act = pend_q & en_q;

    // A clearing write never blocks a same-cycle edge, so that case is not an overflow
    assign ovf_set = evt & pend_q & ~pend_clr;

    // Clear masks from PEND/OVF write-1-to-clear and from the ACK index
    always_comb begin
        pend_clr = '0;
        ovf_clr  = '0;
        if (wr_pend) begin
            pend_clr = bus.iobus_out[N_SRC-1:0];
        end
        if (wr_ack) begin
            for (int i = 0; i < int'(N_SRC); i++) begin
                if (bus.iobus_out == 32'(i)) begin
                    pend_clr[i] = 1'b1;
                end
            end
        end
        if (wr_ovf) begin
            ovf_clr = bus.iobus_out[N_SRC-1:0];
        end
    end

    // Source history, pending, enable and overflow registers; set beats clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_q  <= '0;
            pend_q <= '0;
            en_q   <= '0;
            ovf_q  <= '0;
        end else begin
            src_q  <= src;
            pend_q <= (pend_q & ~pend_clr) | evt;
            ovf_q  <= (ovf_q & ~ovf_clr) | ovf_set;
            if (wr_en) begin
                en_q <= bus.iobus_out[N_SRC-1:0];
            end
        end
    end

    prio_enc #(
        .N   (N_SRC),
        .IdW (IdW)
    ) u_prio_enc (
        .req_i   (act),
        .valid_o (act_valid),
        .idx_o   (act_id)
    );

    assign intr_id = act_id;

    // INTR sequencer; an ACK wins over act dropping in the same cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            intr    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (act_valid) begin
                        state_q <= ASSERT;
                        intr    <= 1'b1;
                    end
                end
                ASSERT: begin
                    if (wr_ack) begin
                        state_q <= HOLDOFF;
                        cnt_q   <= CntW'(HOLDOFF_CYC - 1);
                        intr    <= 1'b0;
                    end else if (!act_valid) begin
                        state_q <= IDLE;
                        intr    <= 1'b0;
                    end
                end
                HOLDOFF: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    intr    <= 1'b0;
                end
            endcase
        end
    end

    // Read mux; misses return 0 so the wrapper can OR all peripherals together
    always_comb begin
        rd_data = '0;
        if (hit_pend) begin
            rd_data = 32'(pend_q);
        end else if (hit_en) begin
            rd_data = 32'(en_q);
        end else if (hit_id) begin
            rd_data = {act_valid, 31'(act_id)};
        end else if (hit_ovf) begin
            rd_data = 32'(ovf_q);
        end
    end

    assign bus.iobus_rd = rd_data;

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_intr_ctrl;

    import intr_pkg::*;

    localparam int          N    = 5;
    localparam int          HOLD = 4;
    localparam logic [31:0] BASE = 32'h1100_D000;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic [N-1:0] src = '0;
    logic         intr;
    logic [2:0]   intr_id;

    intr_ctrl_if bus ();

    intr_ctrl #(
        .N_SRC       (N),
        .HOLDOFF_CYC (HOLD),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .src     (src),
        .bus     (bus),
        .intr    (intr),
        .intr_id (intr_id)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // ---------------- behavioural model ----------------
    bit [N-1:0] m_pend, m_en, m_ovf, m_srcq;
    bit         m_intr;
    int         m_hold;   // cycles of forced-low INTR still to serve

    function automatic int low_idx(input bit [N-1:0] v);
        int r = 0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                r = i;
                break;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_rd();
        bit [N-1:0] a = m_pend & m_en;
        if (bus.iobus_addr == BASE + PEND_OFS) return 32'(m_pend);
        if (bus.iobus_addr == BASE + EN_OFS)   return 32'(m_en);
        if (bus.iobus_addr == BASE + OVF_OFS)  return 32'(m_ovf);
        if (bus.iobus_addr == BASE + ID_OFS)
            return (a != 0) ? (32'h8000_0000 | 32'(low_idx(a))) : 32'h0;
        return 32'h0;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        bit [N-1:0] a, e, clr;
        bit         ack;
        if (!reset_n) begin
            m_pend = '0; m_en = '0; m_ovf = '0; m_srcq = '0;
            m_intr = 1'b0; m_hold = 0;
        end else begin
            a   = m_pend & m_en;
            ack = bus.iobus_wr && (bus.iobus_addr == BASE + ACK_OFS);
            if (m_hold > 0) begin
                m_hold--;
            end else if (m_intr) begin
                if (ack) begin
                    m_intr = 1'b0;
                    m_hold = HOLD;
                end else if (a == 0) begin
                    m_intr = 1'b0;
                end
            end else if (a != 0) begin
                m_intr = 1'b1;
            end
            e   = src & ~m_srcq;
            clr = '0;
            if (bus.iobus_wr && bus.iobus_addr == BASE + PEND_OFS) clr = bus.iobus_out[N-1:0];
            if (ack && bus.iobus_out < N) clr[bus.iobus_out[2:0]] = 1'b1;
            if (bus.iobus_wr && bus.iobus_addr == BASE + OVF_OFS)
                m_ovf = m_ovf & ~bus.iobus_out[N-1:0];
            m_ovf  = m_ovf | (e & m_pend & ~clr);
            m_pend = (m_pend & ~clr) | e;
            if (bus.iobus_wr && bus.iobus_addr == BASE + EN_OFS) m_en = bus.iobus_out[N-1:0];
            m_srcq = src;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // Compare process: outputs are meaningful every cycle
    always @(negedge clk) begin
        chk("intr", 32'(intr), 32'(m_intr));
        chk("intr_id", 32'(intr_id), 32'(low_idx(m_pend & m_en)));
        chk("iobus_rd", bus.iobus_rd, exp_rd());
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic bus_wr(input logic [31:0] ofs, input logic [31:0] data);
        bus.iobus_addr = BASE + ofs;
        bus.iobus_out  = data;
        bus.iobus_wr   = 1'b1;
        tick();
        bus.iobus_wr   = 1'b0;
        bus.iobus_addr = 32'h0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] want);
        bus.iobus_addr = addr;
        #1;
        chk(name, bus.iobus_rd, want);
    endtask

    task automatic pulse(input logic [N-1:0] m);
        src = src | m;
        tick();
        src = src & ~m;
    endtask

    initial begin
        bus.iobus_addr = 32'h0;
        bus.iobus_out  = 32'h0;
        bus.iobus_wr   = 1'b0;
        #2 reset_n = 1'b0;
        #10 reset_n = 1'b1;
        tick();

        // Reset state
        chk("rst_intr", 32'(intr), 32'h0);
        rd_chk("rst_pend", BASE + PEND_OFS, 32'h0);
        rd_chk("rst_id", BASE + ID_OFS, 32'h0);

        // Single source: pend next cycle, intr one cycle later
        bus_wr(EN_OFS, 32'h1F);
        pulse(5'b00100);
        rd_chk("t1_pend", BASE + PEND_OFS, 32'h04);
        chk("t1_intr_early", 32'(intr), 32'h0);
        tick();
        chk("t1_intr", 32'(intr), 32'h1);
        rd_chk("t1_id", BASE + ID_OFS, 32'h8000_0002);
        bus_wr(ACK_OFS, 32'd2);
        idle(6);

        // Priority and holdoff length
        pulse(5'b01010);
        tick();
        rd_chk("t2_id", BASE + ID_OFS, 32'h8000_0001);
        bus_wr(ACK_OFS, 32'd1);
        for (int k = 0; k < HOLD + 1; k++) begin
            chk("t2_holdoff_low", 32'(intr), 32'h0);
            tick();
        end
        chk("t2_reassert", 32'(intr), 32'h1);
        rd_chk("t2_id3", BASE + ID_OFS, 32'h8000_0003);
        bus_wr(ACK_OFS, 32'd3);
        idle(6);

        // Masking while asserted drops intr without holdoff, pend kept
        pulse(5'b00001);
        tick();
        chk("t3_intr", 32'(intr), 32'h1);
        bus_wr(EN_OFS, 32'h0);
        tick();
        chk("t3_intr_fall", 32'(intr), 32'h0);
        rd_chk("t3_pend", BASE + PEND_OFS, 32'h01);
        bus_wr(EN_OFS, 32'h1F);
        idle(2);
        chk("t3_retrigger", 32'(intr), 32'h1);
        bus_wr(ACK_OFS, 32'd0);
        idle(6);

        // Overflow on a second edge before clearing
        pulse(5'b10000);
        tick();
        pulse(5'b10000);
        rd_chk("t4_ovf", BASE + OVF_OFS, 32'h10);
        bus_wr(OVF_OFS, 32'h10);
        rd_chk("t4_ovf_clr", BASE + OVF_OFS, 32'h0);
        bus_wr(ACK_OFS, 32'd4);
        idle(6);

        // ACK colliding with a new edge on the same bit
        pulse(5'b00001);
        tick();
        bus.iobus_addr = BASE + ACK_OFS;
        bus.iobus_out  = 32'd0;
        bus.iobus_wr   = 1'b1;
        src[0]         = 1'b1;
        tick();
        bus.iobus_wr   = 1'b0;
        src[0]         = 1'b0;
        rd_chk("t5_pend", BASE + PEND_OFS, 32'h01);
        rd_chk("t5_ovf", BASE + OVF_OFS, 32'h0);
        chk("t5_intr_low", 32'(intr), 32'h0);
        idle(HOLD + 1);
        chk("t5_reassert", 32'(intr), 32'h1);
        bus_wr(ACK_OFS, 32'd0);
        idle(6);

        // Asynchronous reset mid-assert
        pulse(5'b01010);
        tick();
        chk("t6_intr", 32'(intr), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_intr", 32'(intr), 32'h0);
        rd_chk("t6_rst_pend", BASE + PEND_OFS, 32'h0);
        rd_chk("t6_rst_en", BASE + EN_OFS, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        rd_chk("t6_miss_lo", BASE - 32'h4, 32'h0);
        rd_chk("t6_miss_hi", BASE + 32'h14, 32'h0);
        tick();
        rd_chk("t6_miss_far", BASE + 32'h100, 32'h0);
        rd_chk("t6_miss_zero", 32'h0, 32'h0);
        tick();

        // Randomized traffic, checked by the compare process
        for (int c = 0; c < 3000; c++) begin
            int op;
            src = src ^ (N'($urandom) & N'($urandom));
            op  = $urandom_range(0, 9);
            bus.iobus_out = $urandom;
            bus.iobus_wr  = 1'b0;
            case (op)
                5: begin bus.iobus_addr = BASE + PEND_OFS; bus.iobus_wr = 1'b1; end
                6: begin bus.iobus_addr = BASE + EN_OFS;   bus.iobus_wr = 1'b1; end
                7: begin
                    bus.iobus_addr = BASE + ACK_OFS;
                    bus.iobus_out  = $urandom_range(0, 7);
                    bus.iobus_wr   = 1'b1;
                end
                8: begin bus.iobus_addr = BASE + OVF_OFS;  bus.iobus_wr = 1'b1; end
                9: begin bus.iobus_addr = BASE + 32'h14;   bus.iobus_wr = 1'b1; end
                default: bus.iobus_addr = BASE + 32'(4 * $urandom_range(0, 6));
            endcase
            if ($urandom_range(0, 399) == 0) begin
                reset_n = 1'b0;
                #2 reset_n = 1'b1;
            end
            tick();
        end
        bus.iobus_wr = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Memory-mapped interrupt controller on the OTTER I/O bus, sitting between the wrapper's event sources (debounced/one-shot buttons, timers) and the MCU's single INTR input.
- Each source is edge-captured into a pending register, masked by an enable register and prioritised by a fixed-priority encoder.
- INTR is sequenced through an assert / acknowledge / holdoff handshake.
- Software reads and clears state through the same IOBUS_ADDR / IOBUS_OUT / IOBUS_WR bus the wrapper decodes.

Parameters:
- N_SRC, 5, number of interrupt sources (1..8)
- HOLDOFF_CYC, 4, cycles INTR is forced low after an acknowledge (>=1)
- BASE_ADDR, 32'h1100D000, register block base address; word-aligned offsets 0x0..0x10

Ports:
- clk  in  1  system clock (the MCU's divided clock domain)
- reset_n  in  1  asynchronous active-low reset
- src  in  N_SRC  event inputs, synchronous to clk; rising edge = event
- iobus_addr  in  32  bus address from MCU
- iobus_out  in  32  write data from MCU
- iobus_wr  in  1  write strobe, one cycle per store
- iobus_rd  out  32  read data; 0 when the address misses the block (wrapper ORs into IOBUS_in)
- intr  out  1  level interrupt request to MCU INTR
- intr_id  out  $clog2(N_SRC)  index of the highest-priority active source

Behaviour:
- Reset: pend, en, ovf and src_q are all 0; state=IDLE; holdoff counter=0; intr=0; intr_id=0. iobus_rd is combinational and decodes to 0 for the data registers.
- Edge capture: edge[i] = src[i] & ~src_q[i]; src_q registers src every cycle.
- Pending set: pend[i] is set the cycle after edge[i] (1-cycle latency).
- Overflow: if pend[i] is already 1 when edge[i] arrives, ovf[i] is set (sticky).
- Active vector: act = pend & en. Priority: lowest index wins. intr_id = index of the lowest set bit of act, or 0 if act==0.
- Registers (offset from BASE_ADDR):
  - 0x0 PEND: read pend. Write-1-to-clear.
  - 0x4 EN: read/write, low N_SRC bits.
  - 0x8 ID: read-only. Returns {act!=0, 31-bit zero-extended intr_id}; bit31 = valid.
  - 0xC ACK: write-only, reads 0. Writing value k clears pend[k] and is the acknowledge event. k >= N_SRC clears nothing but still counts as an acknowledge.
  - 0x10 OVF: read ovf. Write-1-to-clear.
  - Unused register bits read 0.
- Set/clear collision: if a clear (PEND W1C or ACK) and edge[i] hit the same bit in the same cycle, set wins; the new event is never lost and ovf is not set.
- State machine (registered; intr is a registered output):
  - IDLE: intr=0. Go to ASSERT when act!=0. intr rises 1 cycle after act becomes nonzero, so an edge-to-intr latency of 2 cycles.
  - ASSERT: intr=1.
    - ACK write: go to HOLDOFF, load counter with HOLDOFF_CYC-1.
    - act becomes 0 without an ACK (masked or W1C'd): go directly to IDLE with no holdoff.
    - ACK takes precedence if both occur in the same cycle.
  - HOLDOFF: intr=0. Decrement the counter each cycle; at 0 go to IDLE. IDLE re-evaluates act, so intr is low for exactly HOLDOFF_CYC+1 cycles minimum. Events during HOLDOFF still set pend.
- EN writes never clear pend; re-enabling a pending source re-triggers intr.
- Async reset mid-operation returns everything to reset values immediately. No event survives reset.

Decomposition:
- Package intr_pkg: register offset localparams (PEND_OFS, EN_OFS, ID_OFS, ACK_OFS, OVF_OFS) and typedef enum logic [1:0] {IDLE, ASSERT, HOLDOFF} intr_state_t.
- One sub-module: prio_enc (parameterised lowest-index-first encoder, outputs valid + index), reusable elsewhere.

Test Plan:
- Reset then EN=0x1F; pulse src[2] → pend=0x04 next cycle, intr=1 two cycles after the edge, ID reads 0x80000002.
- src[1] and src[3] pending, EN=0x1F → ID=0x80000001. ACK write 1 → intr=0 for 5 cycles (HOLDOFF_CYC=4), then intr=1 with ID=0x80000003.
- src[0] pending; write EN=0 while in ASSERT → intr falls next cycle, state IDLE, PEND still reads 0x01.
- Second edge on src[4] before its clear → OVF reads 0x10. Write OVF=0x10 → OVF reads 0.
- ACK write of 0 in the same cycle as a new edge on src[0] → pend[0] stays 1, OVF[0]=0, intr reasserts after holdoff.
- Assert reset_n=0 mid-ASSERT with pend=0x0A → intr=0 and all registers 0 asynchronously. After release, iobus_rd=0 for addresses outside BASE_ADDR..BASE_ADDR+0x10.
